// File: rtl/fir_out_decimator.sv
// Output stage after the 3-tap FIR: drops warm-up samples, decimates, rounds and
// saturates each kept sample to 8 bits and buffers it in a small FWFT FIFO.
module fir_out_decimator #(
  parameter int DEC_FACTOR = 2,
  parameter int WARMUP     = 2,
  parameter int SHIFT      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  input  logic [15:0]                   Yin,
  input  logic                          In_en,
  input  logic                          Flush,
  output logic [7:0]                    Dout,
  output logic                          Dout_valid,
  input  logic                          Dout_ready,
  output logic [$clog2(FIFO_DEPTH):0]   Fifo_count,
  output logic                          Overflow,
  input  logic                          Overflow_clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = (DEC_FACTOR > 1) ? $clog2(DEC_FACTOR) : 1;
  localparam logic [16:0] RND = 17'((2 ** SHIFT) / 2);

  logic [3:0]    warm_q, warm_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    mem_q [FIFO_DEPTH];

  logic        keep, pop, push, drop, full;
  logic [16:0] sum, shifted;
  logic [7:0]  conv_val;

  // Round-half-up at 17 bits so 0xFFFF plus the rounding constant cannot wrap.
  always_comb begin
    sum      = {1'b0, Yin} + RND;
    shifted  = sum >> SHIFT;
    conv_val = (shifted > 17'd255) ? 8'hFF : shifted[7:0];
  end

  always_comb begin
    warm_d  = warm_q;
    phase_d = phase_q;
    keep    = 1'b0;
    if (Flush) begin
      warm_d  = 4'(WARMUP);
      phase_d = '0;
    end else if (In_en) begin
      if (warm_q != 4'd0) begin
        warm_d = warm_q - 4'd1;
      end else begin
        keep    = (phase_q == '0);
        phase_d = (phase_q == PW'(DEC_FACTOR - 1)) ? '0 : phase_q + PW'(1);
      end
    end
  end

  // A full FIFO still accepts a push when the head is leaving in the same cycle.
  always_comb begin
    full       = (count_q == CW'(FIFO_DEPTH));
    pop        = Dout_valid && Dout_ready;
    push       = keep && (!full || pop);
    drop       = keep && full && !pop;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = drop ? 1'b1 : (Overflow_clr ? 1'b0 : overflow_q);
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      warm_q     <= 4'(WARMUP);
      phase_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      warm_q     <= warm_d;
      phase_q    <= phase_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Sample storage is deliberately left out of reset.
  always_ff @(posedge Clk) begin
    if (Rst_n && push) begin
      mem_q[wr_ptr_q] <= conv_val;
    end
  end

  assign Dout_valid = (count_q != '0);
  assign Dout       = Dout_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign Fifo_count = count_q;
  assign Overflow   = overflow_q;

endmodule

// File: doc/fir_out_decimator.md
Name: fir_out_decimator

Overview:
- Output stage placed directly downstream of the 3-tap FIR filter. It consumes the 16-bit unsigned filter output every qualified cycle.
- It discards the filter's pipeline warm-up samples and decimates by a programmable factor.
- Each kept sample is rounded and saturated to 8 bits, then buffered in a small first-word-fall-through FIFO.
- The FIFO presents samples on a valid/ready interface to the next consumer.

Parameters:
- DEC_FACTOR, 2, keep 1 of every DEC_FACTOR post-warm-up samples; legal range 1..16.
- WARMUP, 2, accepted samples discarded after reset or Flush; legal range 0..15.
- SHIFT, 8, right-shift applied before rounding and saturation; legal range 0..8.
- FIFO_DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst_n  input  1  synchronous, active-low reset.
- Yin  input  16  unsigned FIR output sample.
- In_en  input  1  Yin is valid and is accepted this cycle.
- Flush  input  1  restart warm-up and decimation phase (used after a coefficient change).
- Dout  output  8  FIFO head sample.
- Dout_valid  output  1  FIFO non-empty.
- Dout_ready  input  1  consumer accepts Dout this cycle.
- Fifo_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- Overflow  output  1  sticky flag: a kept sample was dropped.
- Overflow_clr  input  1  clears Overflow.

Behaviour:
- Reset (Rst_n=0 at a Clk edge):
  - Clears: warm-up counter, decimation phase, FIFO pointers, Fifo_count, Overflow.
  - Outputs after the edge: Dout_valid=0, Dout=0, Overflow=0, Fifo_count=0.
  - Reset overrides all other inputs.
  - FIFO storage itself is not reset.
- Accept: a sample is accepted on an edge where In_en=1 and Flush=0.
- Warm-up: the first WARMUP accepted samples after reset or Flush are discarded. They do not advance the phase counter.
- Decimation:
  - A phase counter runs 0..DEC_FACTOR-1.
  - The sample is kept when phase==0.
  - Each accepted post-warm-up sample increments the phase, wrapping to 0.
  - DEC_FACTOR=1 keeps every sample.
- Conversion (combinational, applied to kept samples):
  - t = (Yin + (SHIFT>0 ? 2^(SHIFT-1) : 0)) >> SHIFT, computed at 17 bits.
  - Dout value = (t > 255) ? 255 : t[7:0].
  - Rounding is round-half-up.
- Latency: a kept sample presented with In_en at edge N is written at edge N. It is visible on Dout, with Dout_valid=1, in the cycle after edge N if the FIFO was empty.
- FIFO behaviour:
  - First-word-fall-through: Dout is the head entry.
  - Dout is forced to 0 whenever Dout_valid=0.
  - Pop occurs when Dout_valid=1 and Dout_ready=1.
  - Dout_ready is ignored while empty.
- Full with push and no pop: the sample is dropped, Overflow is set, Fifo_count stays at FIFO_DEPTH.
- Full with push and pop in the same cycle: both occur, Fifo_count is unchanged, no overflow.
- Empty with push: count goes 0→1. Dout_valid rises the next cycle; no same-cycle bypass.
- Pointer wrap-around is modulo FIFO_DEPTH. Samples are delivered strictly in order.
- Flush:
  - Reloads the warm-up counter and sets phase to 0.
  - In_en is ignored in the Flush cycle.
  - FIFO contents and Overflow are preserved.
  - A pop in the Flush cycle proceeds normally.
- Overflow_clr:
  - Clears Overflow at the edge.
  - If an overflow drop occurs in the same cycle, set wins and Overflow=1.

Test Plan:
1. Basic stream (defaults, Dout_ready=1):
   - Stimulus: Yin 0x0100, 0x0200, 0x0300, 0x0480, 0x0500, 0x067F on consecutive cycles with In_en.
   - Required: first two discarded; Dout emits 3 then 5; 0x0480 and 0x067F are decimated out; total two valid beats.
2. Rounding/saturation (DEC_FACTOR=1, WARMUP=0):
   - Stimulus: Yin 0x017F, 0x0180, 0xFF7F, 0xFF80, 0xFFFF.
   - Required: Dout 1, 2, 255, 255, 255.
   - Repeat with SHIFT=0 on Yin 0x0042: required Dout 0x42.
3. Backpressure overflow (DEC_FACTOR=1, WARMUP=0, Dout_ready=0):
   - Stimulus: push 5 samples yielding 1..5.
   - Required: Fifo_count=4, Overflow=1, sample 5 dropped.
   - Then raise Dout_ready: required output 1, 2, 3, 4, then Dout_valid=0.
   - Pulse Overflow_clr: required Overflow=0.
4. Full push+pop: FIFO at 4 entries, In_en and Dout_ready both asserted for 3 cycles → Fifo_count stays 4, Overflow stays 0, order preserved across pointer wrap.
5. Flush mid-stream:
   - Stimulus: with 2 entries queued and phase=1, assert Flush for one cycle with In_en=1, then feed 4 samples.
   - Required: FIFO keeps its 2 entries; the Flush-cycle sample is ignored; next 2 samples are discarded; the 3rd is kept and the 4th is decimated out.
6. Reset mid-operation:
   - Stimulus: with 3 entries queued and Overflow=1, pull Rst_n low for one edge.
   - Required: next cycle Dout_valid=0, Dout=0, Fifo_count=0, Overflow=0; the following 2 samples are discarded as warm-up.
